// File: rtl/mul_div_unit.sv
// Multiply/divide unit: one-cycle multiply and a 32-step restoring divider, one operation in flight.
// Optional macro MULDIV_EARLY_OUT_EN: divides with |dividend| < |divisor| finish right after accept.
module mul_div_unit #(
    parameter int ROB_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_multop,
    input  logic [31:0]          in_a,
    input  logic [31:0]          in_b,
    input  logic [ROB_IDX_W-1:0] in_rob_idx,
    input  logic [4:0]           in_rd_addr,
    output logic                 out_valid,
    output logic [31:0]          out_data,
    output logic [ROB_IDX_W-1:0] out_rob_idx,
    output logic [4:0]           out_rd_addr,
    input  logic                 out_ready
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;

    state_t               state;
    logic [4:0]           cnt;
    logic [2:0]           op_q;
    logic [31:0]          a_q;
    logic [31:0]          b_q;
    logic [31:0]          rem_q;
    logic                 neg_quo_q;
    logic                 neg_rem_q;
    logic [ROB_IDX_W-1:0] rob_q;
    logic [4:0]           rd_q;

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    assign in_ready = rst_n && (state == IDLE) && !flush;

    // Issue-side decode: magnitudes and the cases that skip iteration.
    logic        in_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic        div_ovf;
    logic        div_short;
    logic [31:0] quick_res;

    always_comb begin
        in_signed = in_multop[2] & ~in_multop[0];
        a_neg     = in_signed & in_a[31];
        b_neg     = in_signed & in_b[31];
        a_mag     = neg_if(in_a, a_neg);
        b_mag     = neg_if(in_b, b_neg);
        div_zero  = (in_b == 32'd0);
        div_ovf   = in_signed && (in_a == 32'h8000_0000) && (in_b == 32'hFFFF_FFFF);
`ifdef MULDIV_EARLY_OUT_EN
        div_short = !div_zero && !div_ovf && (a_mag < b_mag);
`else
        div_short = 1'b0;
`endif
        if (div_zero)
            quick_res = in_multop[1] ? in_a : 32'hFFFF_FFFF;
        else if (div_ovf)
            quick_res = in_multop[1] ? 32'd0 : 32'h8000_0000;
        else
            quick_res = in_multop[1] ? in_a : 32'd0;
    end

    // Multiply: operands widened to 64 bits so one signed product serves all four variants.
    logic signed [63:0] mul_a;
    logic signed [63:0] mul_b;
    logic signed [63:0] prod;
    logic [31:0]        mul_res;

    always_comb begin
        mul_a   = (op_q == OP_MULH || op_q == OP_MULHSU) ? $signed({{32{a_q[31]}}, a_q})
                                                         : $signed({32'd0, a_q});
        mul_b   = (op_q == OP_MULH) ? $signed({{32{b_q[31]}}, b_q}) : $signed({32'd0, b_q});
        prod    = mul_a * mul_b;
        mul_res = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];
    end

    // Restoring divide step: a_q shifts dividend bits out and quotient bits in.
    logic [32:0] shifted;
    logic        q_bit;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;
    logic [31:0] div_res;

    always_comb begin
        shifted = {rem_q, a_q[31]};
        q_bit   = (shifted >= {1'b0, b_q});
        rem_nxt = q_bit ? (shifted[31:0] - b_q) : shifted[31:0];
        quo_nxt = {a_q[30:0], q_bit};
        div_res = op_q[1] ? neg_if(rem_nxt, neg_rem_q) : neg_if(quo_nxt, neg_quo_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 5'd0;
            op_q        <= 3'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            rem_q       <= 32'd0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            rob_q       <= '0;
            rd_q        <= 5'd0;
            out_valid   <= 1'b0;
            out_data    <= 32'd0;
            out_rob_idx <= '0;
            out_rd_addr <= 5'd0;
        end else if (flush) begin
            state       <= IDLE;
            cnt         <= 5'd0;
            out_valid   <= 1'b0;
            out_data    <= 32'd0;
            out_rob_idx <= '0;
            out_rd_addr <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q      <= in_multop;
                        rob_q     <= in_rob_idx;
                        rd_q      <= in_rd_addr;
                        cnt       <= 5'd0;
                        rem_q     <= 32'd0;
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        if (!in_multop[2]) begin
                            a_q   <= in_a;
                            b_q   <= in_b;
                            state <= MUL;
                        end else begin
                            a_q <= a_mag;
                            b_q <= b_mag;
                            if (div_zero || div_ovf || div_short) begin
                                state       <= DONE;
                                out_valid   <= 1'b1;
                                out_data    <= quick_res;
                                out_rob_idx <= in_rob_idx;
                                out_rd_addr <= in_rd_addr;
                            end else begin
                                state <= DIV;
                            end
                        end
                    end
                end
                MUL: begin
                    state       <= DONE;
                    out_valid   <= 1'b1;
                    out_data    <= mul_res;
                    out_rob_idx <= rob_q;
                    out_rd_addr <= rd_q;
                end
                DIV: begin
                    rem_q <= rem_nxt;
                    a_q   <= quo_nxt;
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        out_data    <= div_res;
                        out_rob_idx <= rob_q;
                        out_rd_addr <= rd_q;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid   <= 1'b0;
                        out_data    <= 32'd0;
                        out_rob_idx <= '0;
                        out_rd_addr <= 5'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized operations vs a reference model.
`timescale 1ns/1ps
module tb_mul_div_unit;
    localparam int ROB_IDX_W = 5;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_multop;
    logic [31:0]          in_a;
    logic [31:0]          in_b;
    logic [ROB_IDX_W-1:0] in_rob_idx;
    logic [4:0]           in_rd_addr;
    logic                 out_valid;
    logic [31:0]          out_data;
    logic [ROB_IDX_W-1:0] out_rob_idx;
    logic [4:0]           out_rd_addr;
    logic                 out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.ROB_IDX_W(ROB_IDX_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_multop   (in_multop),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_rob_idx  (in_rob_idx),
        .in_rd_addr  (in_rd_addr),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_rob_idx (out_rob_idx),
        .out_rd_addr (out_rd_addr),
        .out_ready   (out_ready)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // Reference model: RISC-V M-extension semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            3'd0: r = sa * sb;
            3'd1: r = (sa * sb) >>> 32;
            3'd2: r = (sa * ub) >>> 32;
            3'd3: r = (ua * ub) >> 32;
            3'd4: r = (b == 0) ? -1 : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? sa : sa / sb;
            3'd5: r = (b == 0) ? -1 : ua / ub;
            3'd6: r = (b == 0) ? sa : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 0 : sa % sb;
            default: r = (b == 0) ? ua : ua % ub;
        endcase
        return r[31:0];
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit     sgn;
        longint ma, mb;
        sgn = (op == 3'd4) || (op == 3'd6);
        if (op < 3'd4) return 2;
        if (b == 0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        ma = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        mb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
`ifdef MULDIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`endif
        return 33;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rob, input logic [4:0] rd);
        @(negedge clk);
        check_val("in_ready_before_issue", in_ready, 1'b1);
        in_valid   = 1'b1;
        in_multop  = op;
        in_a       = a;
        in_b       = b;
        in_rob_idx = rob;
        in_rd_addr = rd;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] want, input int want_lat, input int stall);
        logic [4:0] rob, rd;
        int         lat;
        rob = 5'($urandom);
        rd  = 5'($urandom);
        issue(op, a, b, rob, rd);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_val({tag, "_latency"}, lat, want_lat);
        check_val({tag, "_data"}, out_data, want);
        check_val({tag, "_rob"}, out_rob_idx, rob);
        check_val({tag, "_rd"}, out_rd_addr, rd);
        check_val({tag, "_ready_in_done"}, in_ready, 1'b0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_val({tag, "_hold_valid"}, out_valid, 1'b1);
            check_val({tag, "_hold_data"}, out_data, want);
            check_val({tag, "_hold_ready"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_val({tag, "_consumed_valid"}, out_valid, 1'b0);
        check_val({tag, "_consumed_data"}, out_data, 32'd0);
        check_val({tag, "_idle_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          seen;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [31:0] specials [5];
        specials[0] = 32'd0;
        specials[1] = 32'd1;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_multop = 3'd0; in_a = 32'd0; in_b = 32'd0; in_rob_idx = '0; in_rd_addr = 5'd0;
        #2;
        check_val("reset_in_ready", in_ready, 1'b0);
        check_val("reset_out_valid", out_valid, 1'b0);
        check_val("reset_out_data", out_data, 32'd0);
        check_val("reset_out_rob", out_rob_idx, 5'd0);
        check_val("reset_out_rd", out_rd_addr, 5'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_reset_in_ready", in_ready, 1'b1);

        run_op("mulh_m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2, 0);
        run_op("mulhu_m1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 1);
        run_op("mul_m1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2, 0);
        run_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0);
        run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
        run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
        run_op("divu_by0", 3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("remu_by0", 3'd7, 32'd100, 32'd0, 32'd100, 1, 0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
`ifdef MULDIV_EARLY_OUT_EN
        run_op("divu_3_10", 3'd5, 32'd3, 32'd10, 32'd0, 1, 5);
        run_op("rem_short", 3'd6, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, 1, 0);
`else
        run_op("divu_3_10", 3'd5, 32'd3, 32'd10, 32'd0, 33, 5);
        run_op("rem_short", 3'd6, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, 33, 0);
`endif

        // Flush at N+10 of a divide.
        issue(3'd4, 32'h0123_4567, 32'd3, 5'd1, 5'd2);
        seen = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        flush = 1'b1;
        #1;
        check_val("flush_gates_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check_val("flush_ready_n11", in_ready, 1'b1);
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check_val("flush_no_valid", seen, 0);

        // Flush beats out_ready and in_valid while a result is waiting.
        issue(3'd0, 32'd6, 32'd7, 5'd3, 5'd4);
        @(negedge clk);
        @(negedge clk);
        check_val("flush_done_valid", out_valid, 1'b1);
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_val("flush_done_cleared", out_valid, 1'b0);
        check_val("flush_done_data", out_data, 32'd0);
        check_val("flush_done_idle", in_ready, 1'b1);

        // Reset mid-divide, then reset while a result is presented.
        issue(3'd5, 32'hDEAD_BEEF, 32'd7, 5'd5, 5'd6);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("rst_div_in_ready", in_ready, 1'b0);
        check_val("rst_div_valid", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check_val("rst_div_abandoned", seen, 0);
        issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, 5'd8);
        @(negedge clk);
        @(negedge clk);
        check_val("rst_done_valid_before", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_val("rst_done_valid", out_valid, 1'b0);
        check_val("rst_done_data", out_data, 32'd0);
        check_val("rst_done_rob", out_rob_idx, 5'd0);
        check_val("rst_done_rd", out_rd_addr, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 60; t++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom; b = 32'($urandom_range(0, 20)); end
                2: begin a = specials[$urandom_range(0, 4)]; b = specials[$urandom_range(0, 4)]; end
                default: begin a = 32'($urandom_range(0, 50)); b = $urandom; end
            endcase
            if ($urandom_range(0, 1) == 1 && b > 32'd20 && b < 32'hFFFF_FFEC) b = -b;
            run_op("rand", op, a, b, ref_result(op, a, b), ref_latency(op, a, b), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
